cm0_pmu_cdc_req_ctrl: RTL

Sender-side controller for a 4-phase request/acknowledge handshake between the PMU clock domain and an asynchronous remote domain.
It sequences the enables and data inputs of external CDC-safe send registers: a DW-bit payload register, and a set-type request register whose output REQn idles high.
It synchronises the returning active-low acknowledge (ACKn).
It presents a valid/ready interface to local PMU logic, with completion and timeout-error pulses.

---
 rtl/cm0_pmu_cdc_req_ctrl_if.sv | 26 ++
 rtl/cm0_pmu_cdc_req_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cm0_pmu_cdc_req_ctrl_if.sv
// Bundle between the PMU-side requester/remote link and the CDC request controller.
// Valid/ready: a request transfers on a rising FCLK edge where REQVALID and REQREADY are both high; REQDATA is sampled only on that edge.
interface cm0_pmu_cdc_req_ctrl_if #(
    parameter int DW = 4
);
    logic          REQVALID;
    logic [DW-1:0] REQDATA;
    logic          REQREADY;
    logic          DONE;
    logic          TMOERR;
    logic          ACKn;
    logic          CDCDATAEN;
    logic [DW-1:0] CDCDATADI;
    logic          CDCREQEN;
    logic          CDCREQDI;

    modport master (
        output REQVALID, REQDATA, ACKn,
        input  REQREADY, DONE, TMOERR, CDCDATAEN, CDCDATADI, CDCREQEN, CDCREQDI
    );

    modport slave (
        input  REQVALID, REQDATA, ACKn,
        output REQREADY, DONE, TMOERR, CDCDATAEN, CDCDATADI, CDCREQEN, CDCREQDI
    );
endinterface

// File: rtl/cm0_pmu_cdc_req_ctrl.sv
// Sender-side 4-phase REQn/ACKn controller driving external CDC-safe send registers.
// Every CDC* output is a flop so the send-register enables cannot glitch.
module cm0_pmu_cdc_req_ctrl #(
    parameter int DW   = 4,
    parameter int SYNC = 2,
    parameter int TMO  = 0
) (
    input  logic                  FCLK,
    input  logic                  PORESETn,
    cm0_pmu_cdc_req_ctrl_if.slave bus,
    output logic [2:0]            dbg_state
);
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TMO > 0) ? CW'(TMO - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_RELEASE  = 3'd4,
        S_WAIT_REL = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [SYNC-1:0] sync_q, sync_d;
    logic            data_en_q, data_en_d;
    logic [DW-1:0]   data_di_q, data_di_d;
    logic            req_en_q, req_en_d;
    logic            req_di_q, req_di_d;
    logic            done_q, done_d;
    logic            tmoerr_q, tmoerr_d;
    logic            abort_q, abort_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ack_s;
    logic            req_ready;
    logic            tmo_hit;

    assign ack_s   = sync_q[SYNC-1];
    assign tmo_hit = (TMO != 0) && (cnt_q == TMO_LAST);

    // The DONE cycle is excluded so the next accept lands strictly after it.
    assign req_ready = PORESETn & (state_q == S_IDLE) & ack_s & ~done_q;

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC-2:0], bus.ACKn};
        data_en_d = 1'b0;
        data_di_d = data_di_q;
        req_en_d  = 1'b0;
        req_di_d  = req_di_q;
        done_d    = 1'b0;
        tmoerr_d  = 1'b0;
        abort_d   = abort_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.REQVALID && req_ready) begin
                    state_d   = S_LOAD;
                    data_en_d = 1'b1;
                    data_di_d = bus.REQDATA;
                end
            end
            S_LOAD: begin
                state_d  = S_REQ;
                req_en_d = 1'b1;
                req_di_d = 1'b0;
            end
            S_REQ: begin
                state_d = S_WAIT_ACK;
                cnt_d   = '0;
            end
            S_WAIT_ACK: begin
                if (!ack_s) begin
                    state_d  = S_RELEASE;
                    req_en_d = 1'b1;
                    req_di_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d  = S_RELEASE;
                    req_en_d = 1'b1;
                    req_di_d = 1'b1;
                    abort_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (ack_s) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    tmoerr_d = abort_q;
                    abort_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q   <= S_IDLE;
            sync_q    <= '1;
            data_en_q <= 1'b0;
            data_di_q <= '0;
            req_en_q  <= 1'b0;
            req_di_q  <= 1'b1;
            done_q    <= 1'b0;
            tmoerr_q  <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            data_en_q <= data_en_d;
            data_di_q <= data_di_d;
            req_en_q  <= req_en_d;
            req_di_q  <= req_di_d;
            done_q    <= done_d;
            tmoerr_q  <= tmoerr_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.REQREADY  = req_ready;
    assign bus.DONE      = done_q;
    assign bus.TMOERR    = tmoerr_q;
    assign bus.CDCDATAEN = data_en_q;
    assign bus.CDCDATADI = data_di_q;
    assign bus.CDCREQEN  = req_en_q;
    assign bus.CDCREQDI  = req_di_q;
    assign dbg_state     = state_q;
endmodule
